// File: rtl/bus_host_arb.sv
// Two-host round-robin arbiter onto a single req/gnt/rvalid device port.
// A small ID FIFO remembers which host owns each outstanding response.
module bus_host_arb #(
  parameter int BusWidth       = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                host_req_i,
  input  logic [1:0]                host_we_i,
  input  logic [2*BusWidth-1:0]     host_addr_i,
  input  logic [2*BusWidth/8-1:0]   host_be_i,
  input  logic [2*BusWidth-1:0]     host_wdata_i,
  output logic [1:0]                host_gnt_o,
  output logic [1:0]                host_rvalid_o,
  output logic [BusWidth-1:0]       host_rdata_o,
  output logic                      dev_req_o,
  output logic                      dev_we_o,
  output logic [BusWidth-1:0]       dev_addr_o,
  output logic [BusWidth-1:0]       dev_wdata_o,
  output logic [BusWidth/8-1:0]     dev_be_o,
  input  logic                      dev_gnt_i,
  input  logic                      dev_rvalid_i,
  input  logic [BusWidth-1:0]       dev_rdata_i,
  output logic                      err_o
);

  localparam int BeW  = BusWidth / 8;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              sel, sel_q, prio_q;
  logic              id_mem [MaxOutstanding];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              err_q;
  logic              full, empty, accept, pop, head;

  assign full   = (count_q == CntW'(MaxOutstanding));
  assign empty  = (count_q == '0);
  assign accept = dev_req_o && dev_gnt_i;
  assign pop    = dev_rvalid_i && !empty;
  assign head   = id_mem[rd_ptr_q];
  assign err_o  = err_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dev_req_o && !dev_gnt_i) state_d = HOLD;
      HOLD:    if (dev_gnt_i || !host_req_i[sel_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (state_q == HOLD) begin
      sel = sel_q;
    end else begin
      case (host_req_i)
        2'b01:   sel = 1'b0;
        2'b10:   sel = 1'b1;
        default: sel = prio_q;
      endcase
    end
    dev_req_o   = host_req_i[sel] && !full;
    dev_we_o    = host_we_i[sel];
    dev_addr_o  = sel ? host_addr_i[2*BusWidth-1:BusWidth]  : host_addr_i[BusWidth-1:0];
    dev_wdata_o = sel ? host_wdata_i[2*BusWidth-1:BusWidth] : host_wdata_i[BusWidth-1:0];
    dev_be_o    = sel ? host_be_i[2*BeW-1:BeW]              : host_be_i[BeW-1:0];
    host_gnt_o       = 2'b00;
    host_gnt_o[sel]  = dev_req_o && dev_gnt_i;
    host_rvalid_o    = 2'b00;
    if (!empty) host_rvalid_o[head] = dev_rvalid_i;
    host_rdata_o     = dev_rdata_i;
  end

  // In HOLD sel already equals sel_q, so an unconditional load keeps it stable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q    <= 1'b0;
      prio_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      sel_q <= sel;
      if (accept) begin
        prio_q   <= ~sel;
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({accept, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (dev_rvalid_i && empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) id_mem[wr_ptr_q] <= sel;
  end

endmodule
